// File: rtl/calc_scoreboard_if.sv
// Response buses into the calc scoreboard and its result outputs.
// master drives the ref/DUV responses; slave is the scoreboard itself.
interface calc_scoreboard_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int RESP_W    = 2
);
  logic [NUM_PORTS*DATA_W-1:0] ref_out_data;
  logic [NUM_PORTS*RESP_W-1:0] ref_out_resp;
  logic [NUM_PORTS*DATA_W-1:0] duv_out_data;
  logic [NUM_PORTS*RESP_W-1:0] duv_out_resp;
  logic [NUM_PORTS-1:0]        mismatch;
  logic [NUM_PORTS-1:0]        timeout;
  logic [NUM_PORTS-1:0]        overflow;
  logic [15:0]                 match_count;
  logic [15:0]                 err_count;
  logic                        any_error;
  logic                        busy;

  modport master (
    output ref_out_data, ref_out_resp, duv_out_data, duv_out_resp,
    input  mismatch, timeout, overflow, match_count, err_count, any_error, busy
  );

  modport slave (
    input  ref_out_data, ref_out_resp, duv_out_data, duv_out_resp,
    output mismatch, timeout, overflow, match_count, err_count, any_error, busy
  );
endinterface

// File: rtl/calc_scoreboard.sv
// Latency-tolerant scoreboard: per-port FIFOs of reference responses matched in order
// against later DUV responses. Define CALC_SB_DISPLAY_EN to log each error event.
module calc_scoreboard #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int RESP_W    = 2,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 15
) (
  input logic              c_clk,
  input logic              reset,
  calc_scoreboard_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam int SUM_W = $clog2(NUM_PORTS + 1);
  localparam logic [RESP_W-1:0] RESP_SUCC = RESP_W'(1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
  } entry_t;

  function automatic logic entry_match(entry_t exp_v, entry_t act_v);
    return (exp_v.resp === act_v.resp) &&
           ((exp_v.resp !== RESP_SUCC) || (exp_v.data === act_v.data));
  endfunction

  logic [NUM_PORTS-1:0] pass_v, mis_v, tmo_v, ovf_v, busy_v;
  logic [NUM_PORTS-1:0] mismatch_q, timeout_q, overflow_q;
  logic [15:0]          match_count_q, match_count_d;
  logic [15:0]          err_count_q, err_count_d;
  logic                 any_error_q, any_error_d;
  logic [SUM_W-1:0]     n_pass, n_err;
  logic [16:0]          match_sum, err_sum;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    entry_t           mem_q [DEPTH];
    entry_t           ref_e, duv_e, head_e, exp_e;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             ref_ev, duv_ev, empty, full, cmp_ok;
    logic             push, pop, pass, mis, tmo, ovf;

    assign ref_e  = {sb.ref_out_data[gi*DATA_W +: DATA_W], sb.ref_out_resp[gi*RESP_W +: RESP_W]};
    assign duv_e  = {sb.duv_out_data[gi*DATA_W +: DATA_W], sb.duv_out_resp[gi*RESP_W +: RESP_W]};
    assign head_e = mem_q[rd_ptr_q];
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign ref_ev = (ref_e.resp != '0);
    // Case inequality so an X/Z DUV response still counts as an event.
    assign duv_ev = (duv_e.resp !== '0);
    // With an empty FIFO the simultaneous ref response is compared directly.
    assign exp_e  = empty ? ref_e : head_e;
    assign cmp_ok = entry_match(exp_e, duv_e);

    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      age_d    = age_q;
      push     = 1'b0;
      pop      = 1'b0;
      pass     = 1'b0;
      mis      = 1'b0;
      tmo      = 1'b0;
      ovf      = 1'b0;
      if (duv_ev) begin
        if (empty && !ref_ev) begin
          mis = 1'b1;
        end else begin
          pass = cmp_ok;
          mis  = !cmp_ok;
          if (!empty) begin
            pop  = 1'b1;
            push = ref_ev;
          end
        end
      end else if (!empty && (age_q == AGE_W'(TIMEOUT))) begin
        pop  = 1'b1;
        tmo  = 1'b1;
        push = ref_ev;
      end else if (ref_ev) begin
        if (full) ovf = 1'b1;
        else      push = 1'b1;
      end

      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      // Age measures how long the current head has waited.
      if (pop || (push && empty)) age_d = '0;
      else if (!empty)            age_d = age_q + AGE_W'(1);
    end

    always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        age_q    <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        age_q    <= age_d;
      end
    end

    always_ff @(posedge c_clk) begin
      if (push) mem_q[wr_ptr_q] <= ref_e;
    end

    assign pass_v[gi] = pass;
    assign mis_v[gi]  = mis;
    assign tmo_v[gi]  = tmo;
    assign ovf_v[gi]  = ovf;
    assign busy_v[gi] = !empty;

`ifdef CALC_SB_DISPLAY_EN
    always @(posedge c_clk) begin
      if (!reset && (mis || tmo || ovf)) begin
        $display("%0t calc_scoreboard port %0d %s: exp resp=%0d data=%h act resp=%0d data=%h",
                 $time, gi,
                 (mis && empty && !ref_ev) ? "unexpected" :
                 mis ? "mismatch" : tmo ? "timeout" : "overflow",
                 exp_e.resp, exp_e.data,
                 ovf ? ref_e.resp : duv_e.resp, ovf ? ref_e.data : duv_e.data);
      end
    end
`else
    // Synthesizable build carries no diagnostic output.
`endif
  end

  always_comb begin
    n_pass = '0;
    n_err  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      n_pass = n_pass + SUM_W'(pass_v[p]);
      n_err  = n_err + SUM_W'(mis_v[p] | tmo_v[p] | ovf_v[p]);
    end
    match_sum     = {1'b0, match_count_q} + 17'(n_pass);
    err_sum       = {1'b0, err_count_q} + 17'(n_err);
    match_count_d = match_sum[16] ? 16'hFFFF : match_sum[15:0];
    err_count_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    any_error_d   = any_error_q | (n_err != '0);
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      mismatch_q    <= '0;
      timeout_q     <= '0;
      overflow_q    <= '0;
      match_count_q <= '0;
      err_count_q   <= '0;
      any_error_q   <= 1'b0;
    end else begin
      mismatch_q    <= mis_v;
      timeout_q     <= tmo_v;
      overflow_q    <= ovf_v;
      match_count_q <= match_count_d;
      err_count_q   <= err_count_d;
      any_error_q   <= any_error_d;
    end
  end

  assign sb.mismatch    = mismatch_q;
  assign sb.timeout     = timeout_q;
  assign sb.overflow    = overflow_q;
  assign sb.match_count = match_count_q;
  assign sb.err_count   = err_count_q;
  assign sb.any_error   = any_error_q;
  assign sb.busy        = |busy_v;
endmodule
